// File: rtl/pwm_comp_dt_gen_if.sv
// Settings, handshake and gate-drive bundle for one complementary PWM leg.
// master drives settings/fault requests, slave is the generator.
interface pwm_comp_dt_gen_if #(
  parameter int CNT_W = 10,
  parameter int DT_W  = 9
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [DT_W-1:0]  dead_time;
  logic             center_mode;
  logic             load;
  logic             load_ack;
  logic             cycle_start;
  logic [CNT_W-1:0] counter;
  logic             fault;
  logic             fault_clr;
  logic             fault_latched;
  logic             pwm_hi;
  logic             pwm_lo;

  modport master (
    output period, duty, dead_time, center_mode, load, fault, fault_clr,
    input  load_ack, cycle_start, counter, fault_latched, pwm_hi, pwm_lo
  );

  modport slave (
    input  period, duty, dead_time, center_mode, load, fault, fault_clr,
    output load_ack, cycle_start, counter, fault_latched, pwm_hi, pwm_lo
  );
endinterface

// File: rtl/pwm_comp_dt_gen.sv
// Complementary PWM generator with shadowed period/duty/dead-time settings,
// edge- or center-aligned counting, dead-time insertion and a fault latch.
module pwm_comp_dt_gen #(
  parameter int CNT_W = 10,
  parameter int DT_W  = 9
) (
  input logic             clock_in,
  input logic             reset,
  pwm_comp_dt_gen_if.slave bus
);

  typedef struct packed {
    logic             center;
    logic [DT_W-1:0]  dt;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] period;
  } cfg_t;

  localparam cfg_t CFG_RST = cfg_t'{1'b0, {DT_W{1'b0}}, {CNT_W{1'b0}}, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       dir_q, dir_d;
  logic             term;
  logic             ack_q, cs_q;

  logic             ref_now, ref_q, chg, restart;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic             hi_q, hi_d, lo_q, lo_d;
  logic             lat_q, lat_d;

  // Counter next state; term marks the cycle whose successor is counter 0.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    term  = 1'b0;
    if (!act_q.center) begin
      if (cnt_q >= act_q.period) term = 1'b1;
      else                       cnt_d = cnt_q + CNT_ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= act_q.period) begin
        // P of 0 or 1 has no down-slope left before wrapping to 0
        if (act_q.period <= CNT_ONE) term = 1'b1;
        else begin
          cnt_d = act_q.period - CNT_ONE;
          dir_d = DIR_DN;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      if (cnt_q <= CNT_ONE) term = 1'b1;
      else                  cnt_d = cnt_q - CNT_ONE;
    end
    if (term) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end
  end

  // Shadow capture on load; shadow moves to active only at a period boundary.
  // A load in the terminal cycle refills the shadow and keeps pending set.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (term && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (bus.load) begin
      shd_d  = '{center: bus.center_mode, dt: bus.dead_time,
                 duty: bus.duty, period: bus.period};
      pend_d = 1'b1;
    end
  end

  // Counter, settings and boundary pulses.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      act_q  <= CFG_RST;
      shd_q  <= CFG_RST;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      ack_q  <= term & pend_q;
      cs_q   <= term;
    end
  end

  assign ref_now = (cnt_q < act_q.duty);
  assign chg     = ref_now ^ ref_q;
  // clearing the fault latch behaves like a fresh edge: full dead time first
  assign restart = chg | (lat_q & bus.fault_clr);

  // Gate drive next state: fault blanking, then dead-time blanking, else follow ref.
  always_comb begin
    lat_d = bus.fault | (lat_q & ~bus.fault_clr);
    hi_d  = 1'b0;
    lo_d  = 1'b0;
    dt_d  = '0;
    if (bus.fault || (lat_q && !bus.fault_clr)) begin
      dt_d = '0;
    end else if (restart) begin
      if (act_q.dt == '0) begin
        hi_d = ref_now;
        lo_d = ~ref_now;
      end else begin
        // the blanked cycle already being issued counts as the first of DT
        dt_d = act_q.dt - 1'b1;
      end
    end else if (dt_q != '0) begin
      dt_d = dt_q - 1'b1;
    end else begin
      hi_d = ref_now;
      lo_d = ~ref_now;
    end
  end

  // Registered gate outputs, dead timer and fault latch.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
      dt_q  <= '0;
      ref_q <= 1'b0;
      lat_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dt_q  <= dt_d;
      ref_q <= ref_now;
      lat_q <= lat_d;
    end
  end

  assign bus.counter       = cnt_q;
  assign bus.load_ack      = ack_q;
  assign bus.cycle_start   = cs_q;
  assign bus.fault_latched = lat_q;
  assign bus.pwm_hi        = hi_q;
  assign bus.pwm_lo        = lo_q;

endmodule

// File: tb/tb_pwm_comp_dt_gen.sv
// Directed bench for pwm_comp_dt_gen: a period-position model predicts each
// cycle's outputs into a scoreboard queue; plus per-period duty totals.
module tb_pwm_comp_dt_gen;
  localparam int CNT_W = 10;
  localparam int DT_W  = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_comp_dt_gen_if #(.CNT_W(CNT_W), .DT_W(DT_W)) bus();
  pwm_comp_dt_gen #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clock_in (clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    int cnt;
    bit hi, lo, cs, ack, lat;
  } exp_t;
  exp_t sb[$];

  int nvec = 0, nerr = 0;

  // model state: active/shadow settings, position within the period
  int mP, mD, mDT, sP, sD, sDT, mpos, cyc, clr_until;
  bit mC, sC, mpend, mlat;
  bit hist[$];

  int n_hi, n_lo, n_blo, n_cs, n_ack, n_ack_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int mlen();
    if (mP == 0) return 1;
    return mC ? 2 * mP : mP + 1;
  endfunction

  function automatic int mcnt();
    if (!mC) return mpos;
    return (mpos <= mP) ? mpos : 2 * mP - mpos;
  endfunction

  task automatic model_reset();
    mP = (1 << CNT_W) - 1; mD = 0; mDT = 0; mC = 1'b0;
    sP = mP; sD = 0; sDT = 0; sC = 1'b0;
    mpend = 1'b0; mpos = 0; mlat = 1'b0; cyc = 0; clr_until = -1;
    hist.delete();
    repeat (600) hist.push_back(1'b0);
    sb.delete();
  endtask

  // Predict the state visible in the next cycle from this cycle's inputs.
  task automatic model_step();
    int  c;
    bit  r, term, stable, blank;
    exp_t e;
    c    = mcnt();
    r    = (c < mD);
    term = (mpos == mlen() - 1);
    hist.push_back(r);
    void'(hist.pop_front());
    e.hi = 1'b0;
    e.lo = 1'b0;
    blank = bus.fault || (mlat && !bus.fault_clr);
    if (!blank) begin
      if (mlat && bus.fault_clr) clr_until = cyc + mDT;
      // an output follows ref only once ref has held for DT+1 cycles
      stable = 1'b1;
      for (int j = 0; j <= mDT; j++)
        if (hist[hist.size() - 1 - j] != r) stable = 1'b0;
      if (cyc + 1 > clr_until && stable) begin
        e.hi = r;
        e.lo = !r;
      end
    end
    mlat  = bus.fault | (mlat & ~bus.fault_clr);
    e.lat = mlat;
    e.cs  = term;
    e.ack = term & mpend;
    if (term && mpend) begin
      mP = sP; mD = sD; mDT = sDT; mC = sC; mpend = 1'b0;
    end
    if (bus.load) begin
      sP = int'(bus.period); sD = int'(bus.duty); sDT = int'(bus.dead_time);
      sC = bus.center_mode; mpend = 1'b1;
    end
    mpos  = term ? 0 : mpos + 1;
    e.cnt = mcnt();
    cyc++;
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    e = sb.pop_front();
    chk("counter",       32'(bus.counter),       32'(e.cnt));
    chk("pwm_hi",        32'(bus.pwm_hi),        32'(e.hi));
    chk("pwm_lo",        32'(bus.pwm_lo),        32'(e.lo));
    chk("cycle_start",   32'(bus.cycle_start),   32'(e.cs));
    chk("load_ack",      32'(bus.load_ack),      32'(e.ack));
    chk("fault_latched", 32'(bus.fault_latched), 32'(e.lat));
    chk("overlap",       32'(bus.pwm_hi & bus.pwm_lo), 32'd0);
    n_hi     += int'(bus.pwm_hi);
    n_lo     += int'(bus.pwm_lo);
    n_blo    += int'(!bus.pwm_hi && !bus.pwm_lo);
    n_cs     += int'(bus.cycle_start);
    n_ack    += int'(bus.load_ack);
    n_ack_cs += int'(bus.load_ack && bus.cycle_start);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_stats();
    n_hi = 0; n_lo = 0; n_blo = 0; n_cs = 0; n_ack = 0; n_ack_cs = 0;
  endtask

  task automatic measure(input int n);
    clr_stats();
    run(n);
  endtask

  task automatic do_load(input int p, input int d, input int dt, input bit c);
    bus.period      = CNT_W'(p);
    bus.duty        = CNT_W'(d);
    bus.dead_time   = DT_W'(dt);
    bus.center_mode = c;
    bus.load        = 1'b1;
    tick();
    bus.load        = 1'b0;
  endtask

  task automatic wait_ack();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.load_ack !== 1'b1 && k < 3000);
    chk("load_ack_wait", 32'(bus.load_ack), 32'd1);
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (int'(bus.counter) != v && k < 2100) begin
      tick();
      k++;
    end
    chk("counter_reach", 32'(bus.counter), 32'(v));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.period = '0; bus.duty = '0; bus.dead_time = '0; bus.center_mode = 1'b0;
    bus.load = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    #1;
    chk("rst_counter",     32'(bus.counter),       32'd0);
    chk("rst_pwm_hi",      32'(bus.pwm_hi),        32'd0);
    chk("rst_pwm_lo",      32'(bus.pwm_lo),        32'd0);
    chk("rst_cycle_start", 32'(bus.cycle_start),   32'd0);
    chk("rst_load_ack",    32'(bus.load_ack),      32'd0);
    chk("rst_fault",       32'(bus.fault_latched), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // edge P=99 D=40 DT=0
    do_load(99, 40, 0, 1'b0);
    wait_ack();
    run(100);
    measure(100);
    chk("t1_hi",    32'(n_hi),  32'd40);
    chk("t1_lo",    32'(n_lo),  32'd60);
    chk("t1_bothlo",32'(n_blo), 32'd0);
    chk("t1_cs",    32'(n_cs),  32'd1);

    // edge P=99 D=40 DT=5
    do_load(99, 40, 5, 1'b0);
    wait_ack();
    measure(100);
    chk("t2_hi",    32'(n_hi),  32'd35);
    chk("t2_lo",    32'(n_lo),  32'd55);
    chk("t2_bothlo",32'(n_blo), 32'd10);

    // center P=50 D=20 DT=3
    do_load(50, 20, 3, 1'b1);
    wait_ack();
    run(100);
    measure(100);
    chk("t3_hi", 32'(n_hi), 32'd36);
    chk("t3_lo", 32'(n_lo), 32'd58);
    chk("t3_cs", 32'(n_cs), 32'd1);

    // shadow load mid-period, then overwritten shadow
    do_load(99, 40, 0, 1'b0);
    wait_ack();
    clr_stats();
    run(10);
    do_load(99, 70, 0, 1'b0);
    run(89);
    chk("t4_cur_hi", 32'(n_hi),     32'd40);
    chk("t4_ack",    32'(n_ack),    32'd1);
    chk("t4_ack_cs", 32'(n_ack_cs), 32'd1);
    measure(100);
    chk("t4_next_hi", 32'(n_hi), 32'd70);
    clr_stats();
    run(10);
    do_load(99, 50, 0, 1'b0);
    run(19);
    do_load(99, 10, 0, 1'b0);
    run(69);
    chk("t4b_cur_hi", 32'(n_hi),  32'd70);
    chk("t4b_ack",    32'(n_ack), 32'd1);
    measure(100);
    chk("t4b_next_hi", 32'(n_hi), 32'd10);

    // fault latch, fault-wins, clear with DT=5
    do_load(99, 40, 5, 1'b0);
    wait_ack();
    run(100);
    wait_cnt(20);
    bus.fault = 1'b1;
    tick();
    bus.fault = 1'b0;
    chk("t5_lat", 32'(bus.fault_latched), 32'd1);
    chk("t5_hi",  32'(bus.pwm_hi),        32'd0);
    chk("t5_lo",  32'(bus.pwm_lo),        32'd0);
    bus.fault = 1'b1;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault = 1'b0;
    bus.fault_clr = 1'b0;
    chk("t5_both_lat", 32'(bus.fault_latched), 32'd1);
    run(5);
    wait_cnt(60);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("t5_clr_lat", 32'(bus.fault_latched), 32'd0);
    clr_stats();
    chk("t5_blank_lo", 32'(bus.pwm_lo), 32'd0);
    run(4);
    chk("t5_blank_cnt", 32'(n_blo), 32'd4);
    tick();
    chk("t5_resume_lo", 32'(bus.pwm_lo), 32'd1);

    // corner values
    do_load(99, 0, 0, 1'b0);
    wait_ack();
    measure(100);
    chk("t6_d0_lo", 32'(n_lo), 32'd100);
    do_load(99, 100, 0, 1'b0);
    wait_ack();
    measure(100);
    chk("t6_dp1_hi", 32'(n_hi), 32'd100);
    do_load(0, 100, 0, 1'b0);
    wait_ack();
    measure(20);
    chk("t6_p0_cs", 32'(n_cs), 32'd20);

    // reset during dead time, with a pending load that must be dropped
    do_load(99, 40, 5, 1'b0);
    wait_ack();
    wait_cnt(40);
    do_load(99, 70, 5, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_counter", 32'(bus.counter), 32'd0);
    chk("t6_rst_hi",      32'(bus.pwm_hi),  32'd0);
    chk("t6_rst_lo",      32'(bus.pwm_lo),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    measure(1030);
    chk("t6_no_ack", 32'(n_ack), 32'd0);
    chk("t6_cs_1024", 32'(n_cs), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
